// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and geometry defaults.
package rf_dump_reader_pkg;

  localparam int unsigned NREGS_DEF   = 32;
  localparam int unsigned AW_DEF      = 5;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned SKIP_X0_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks the register file through its debug read port and streams {index,data}
// words over valid/ready, accumulating a running checksum of every accepted word.
//
// state | meaning
// IDLE  | waiting for start; read address parked at 0
// FETCH | one cycle: first word loaded from the RF
// SEND  | word presented; each fire loads the next word on the same edge
// DONE  | one cycle: done pulse, then back to IDLE
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned SKIP_X0 = SKIP_X0_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [AW-1:0] rf_raddr_o,
  input  logic [DW-1:0] rf_rdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_idx_o,
  output logic [DW-1:0] out_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] checksum_o
);

  localparam logic [AW:0] FIRST_IDX = (SKIP_X0 != 0) ? (AW+1)'(1) : '0;
  localparam logic [AW:0] LAST_IDX  = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] IDX_INC   = (AW+1)'(1);

  state_e        state_q;
  logic [AW:0]   idx_q;
  logic [AW-1:0] out_idx_q;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] checksum_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  logic fetching;
  logic sending;
  logic fire;
  logic last_word;
  logic start_accept;
  logic load_word;

  assign fetching     = (state_q == ST_FETCH);
  assign sending      = (state_q == ST_SEND);
  assign fire         = out_valid_q & out_ready_i;
  assign last_word    = ({1'b0, out_idx_q} == LAST_IDX);
  assign start_accept = (state_q == ST_IDLE) & start_i & ~abort_i;
  assign load_word    = ~abort_i & (fetching | (sending & fire & ~last_word));

  // idx carries one extra bit so the step past the last register never aliases index 0
  assign rf_raddr_o = ((fetching | sending) & ~idx_q[AW]) ? idx_q[AW-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
            end
          end
          ST_FETCH: begin
            state_q     <= ST_SEND;
            out_valid_q <= 1'b1;
          end
          ST_SEND: begin
            if (fire && last_word) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // A word that fires in the same cycle as abort still counts toward the partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
    end else begin
      if (start_accept) begin
        idx_q      <= FIRST_IDX;
        checksum_q <= '0;
      end else begin
        if (fire) begin
          checksum_q <= checksum_q + out_data_q;
        end
        if (load_word) begin
          out_data_q <= rf_rdata_i;
          out_idx_q  <= idx_q[AW-1:0];
          idx_q      <= idx_q + IDX_INC;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign checksum_o  = checksum_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: RF model, scoreboard of expected words, table-driven
// idle/dump vectors and hand-written abort, reset, coherency and x0 sequences.
module tb_rf_dump_reader;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    logic          start;
    logic          abort;
    logic          exp_busy;
    logic          exp_valid;
    logic [AW-1:0] exp_raddr;
  } idle_vec_t;

  typedef struct {
    int mode;
    int exp_edges;
  } dump_vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rf [NREGS];

  logic          start, abort, out_ready, out_valid, busy, done;
  logic [AW-1:0] rf_raddr, out_idx;
  logic [DW-1:0] rf_rdata, out_data, checksum;

  logic          start_b, abort_b, out_ready_b, out_valid_b, busy_b, done_b;
  logic [AW-1:0] rf_raddr_b, out_idx_b;
  logic [DW-1:0] rf_rdata_b, out_data_b, checksum_b;

  assign rf_rdata   = (rf_raddr == '0) ? '0 : rf[rf_raddr];
  assign rf_rdata_b = (rf_raddr_b == '0) ? '0 : rf[rf_raddr_b];

  rf_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_X0(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_idx_o(out_idx), .out_data_o(out_data),
    .busy_o(busy), .done_o(done), .checksum_o(checksum)
  );

  rf_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_X0(0)) dut_x0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .rf_raddr_o(rf_raddr_b), .rf_rdata_i(rf_rdata_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
    .out_idx_o(out_idx_b), .out_data_o(out_data_b),
    .busy_o(busy_b), .done_o(done_b), .checksum_o(checksum_b)
  );

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor for the SKIP_X0=1 instance
  int    done_cnt   = 0;
  bit    prev_stall = 1'b0;
  word_t prev_w;
  word_t mon_w;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_stall) begin
      check("stall_hold_valid", 64'(out_valid), 64'(1'b1));
      check("stall_hold_idx", 64'(out_idx), 64'(prev_w.idx));
      check("stall_hold_data", 64'(out_data), 64'(prev_w.data));
    end
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_word actual idx=%0d data=%0h required=none", out_idx, out_data);
      end else begin
        mon_w = exp_q.pop_front();
        checks--;
        check("word_idx", 64'(out_idx), 64'(mon_w.idx));
        check("word_data", 64'(out_data), 64'(mon_w.data));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_w     = {out_idx, out_data};
  end

  task automatic push_expected(input int first, input int last, input bit patch,
                               output logic [DW-1:0] sum);
    logic [DW-1:0] d;
    sum = '0;
    for (int i = first; i <= last; i++) begin
      d = (patch && i == 20) ? 32'hDEADBEEF : rf[i];
      exp_q.push_back(word_t'({AW'(i), d}));
      sum = sum + d;
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns edges from start to the done pulse
  task automatic run_dump(input int mode, input int wr_at, output int edges, output bit saw_done);
    int e;
    e        = 0;
    edges    = 0;
    saw_done = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    e     = 1;
    start = 1'b0;
    while (e < 400 && !saw_done) begin
      out_ready = (mode == 1) ? (e % 3 == 0) : 1'b1;
      start     = (mode == 2) && (e == 10 || e == 33);
      if (e == wr_at) rf[20] = 32'hDEADBEEF;
      @(negedge clk);
      if (done) begin
        saw_done = 1'b1;
        edges    = e;
      end else begin
        @(posedge clk);
        #1;
        e++;
      end
    end
  endtask

  task automatic after_dump(input string tag, input logic [DW-1:0] exp_sum, input bit saw,
                            input int edges, input int exp_edges);
    check({tag, "_done_seen"}, 64'(saw), 64'(1'b1));
    if (exp_edges >= 0) check({tag, "_done_latency"}, 64'(edges), 64'(exp_edges));
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
    check({tag, "_done_single"}, 64'(done), 64'(1'b0));
    check({tag, "_busy_after"}, 64'(busy), 64'(1'b0));
    check({tag, "_valid_after"}, 64'(out_valid), 64'(1'b0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_vec_t     ivec [4];
    dump_vec_t     dvec [3];
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] sum_b;
    int            edges;
    int            nb;
    int            dbase;
    bit            saw;

    ivec[0] = '{start: 1'b0, abort: 1'b0, exp_busy: 1'b0, exp_valid: 1'b0, exp_raddr: 5'd0};
    ivec[1] = '{start: 1'b0, abort: 1'b1, exp_busy: 1'b0, exp_valid: 1'b0, exp_raddr: 5'd0};
    ivec[2] = '{start: 1'b1, abort: 1'b1, exp_busy: 1'b0, exp_valid: 1'b0, exp_raddr: 5'd0};
    ivec[3] = '{start: 1'b1, abort: 1'b0, exp_busy: 1'b1, exp_valid: 1'b0, exp_raddr: 5'd1};
    dvec[0] = '{mode: 0, exp_edges: 33};
    dvec[1] = '{mode: 1, exp_edges: -1};
    dvec[2] = '{mode: 2, exp_edges: 33};

    for (int i = 0; i < NREGS; i++) rf[i] = 32'(i) * 32'h11111111;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_raddr", 64'(rf_raddr), 64'(0));
    check("rst_idx", 64'(out_idx), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_checksum", 64'(checksum), 64'(0));
    check("rst_b_valid", 64'(out_valid_b), 64'(1'b0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = ivec[i].start;
      abort = ivec[i].abort;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("idle_vec%0d_busy", i), 64'(busy), 64'(ivec[i].exp_busy));
      check($sformatf("idle_vec%0d_valid", i), 64'(out_valid), 64'(ivec[i].exp_valid));
      check($sformatf("idle_vec%0d_raddr", i), 64'(rf_raddr), 64'(ivec[i].exp_raddr));
      if (ivec[i].exp_busy) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check($sformatf("idle_vec%0d_abort_busy", i), 64'(busy), 64'(1'b0));
      end
    end

    // Start-to-valid latency
    @(posedge clk);
    #1;
    push_expected(1, NREGS - 1, 1'b0, exp_sum);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("lat_fetch_valid", 64'(out_valid), 64'(1'b0));
    check("lat_fetch_busy", 64'(busy), 64'(1'b1));
    @(posedge clk);
    #1;
    check("lat_send_valid", 64'(out_valid), 64'(1'b1));
    check("lat_send_idx", 64'(out_idx), 64'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_expected(1, NREGS - 1, 1'b0, exp_sum);
      run_dump(dvec[i].mode, -1, edges, saw);
      after_dump($sformatf("dump%0d", i), exp_sum, saw, edges, dvec[i].exp_edges);
      check($sformatf("dump%0d_checksum_const", i), 64'(checksum), 64'(32'h111110F0));
    end

    // RF write to x20 while the walk is still below index 20
    @(posedge clk);
    #1;
    push_expected(1, NREGS - 1, 1'b1, exp_sum);
    run_dump(0, 5, edges, saw);
    after_dump("coherency", exp_sum, saw, edges, 33);
    rf[20] = 32'd20 * 32'h11111111;

    // Abort on the 5th fire: partial sum of words 1..5, no done
    @(posedge clk);
    #1;
    push_expected(1, 5, 1'b0, exp_sum);
    dbase = done_cnt;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'(1'b0));
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_checksum", 64'(checksum), 64'(32'hFFFFFFFF));
    check("abort_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(dbase));
    exp_q.delete();

    push_expected(1, NREGS - 1, 1'b0, exp_sum);
    run_dump(0, -1, edges, saw);
    after_dump("restart", exp_sum, saw, edges, 33);

    // Asynchronous reset in the middle of a dump
    @(posedge clk);
    #1;
    push_expected(1, NREGS - 1, 1'b0, exp_sum);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(1'b0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    check("midrst_idx", 64'(out_idx), 64'(0));
    check("midrst_data", 64'(out_data), 64'(0));
    check("midrst_checksum", 64'(checksum), 64'(0));
    check("midrst_raddr", 64'(rf_raddr), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_expected(1, NREGS - 1, 1'b0, exp_sum);
    run_dump(0, -1, edges, saw);
    after_dump("postrst", exp_sum, saw, edges, 33);

    // x0 included: 32 words starting with index 0 / data 0
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    nb    = 0;
    sum_b = '0;
    saw   = 1'b0;
    for (int c = 0; c < 100 && !saw; c++) begin
      @(negedge clk);
      if (out_valid_b) begin
        if (nb == 0) check("x0_first_data", 64'(out_data_b), 64'(0));
        check("x0_word_idx", 64'(out_idx_b), 64'(nb));
        check("x0_word_data", 64'(out_data_b), 64'(rf[nb]));
        sum_b = sum_b + rf[nb];
        nb++;
      end
      if (done_b) saw = 1'b1;
    end
    check("x0_done_seen", 64'(saw), 64'(1'b1));
    check("x0_word_count", 64'(nb), 64'(32));
    check("x0_checksum", 64'(checksum_b), 64'(sum_b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
